boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/boot_loader.sv | 172 +++++++++++++++++
 tb/tb_boot_loader.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared processor package: boot frame marker, address type and loader FSM states.
// Imported by boot_loader and by anything that observes its debug state.
package cpu_pkg;

   localparam logic [7:0] BOOT_SYNC_DEFAULT = 8'hA5;

   typedef logic [15:0] addr_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR_LO = 3'd1,
      ST_ADDR_HI = 3'd2,
      ST_LEN_LO  = 3'd3,
      ST_LEN_HI  = 3'd4,
      ST_DATA    = 3'd5,
      ST_CSUM    = 3'd6,
      ST_CHECK   = 3'd7
   } boot_state_e;

   // Frame checksum is a plain modulo-256 running sum.
   function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
      return sum + b;
   endfunction

endpackage

// File: rtl/boot_loader.sv
// Serial boot loader: parses SYNC/addr/len/data/checksum frames into byte writes
// on the processor memory and releases cpu_hold only after a good checksum.
module boot_loader
   import cpu_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = BOOT_SYNC_DEFAULT,
   parameter int         TIMEOUT   = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        mem_we,
   output addr_t       mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_err,
   output boot_state_e dbg_state
);

   // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
   // in_ready depends only on the state register and is low only in CHECK.

   localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   boot_state_e   state_q, state_d;
   addr_t         addr_q, addr_d;
   logic [15:0]   len_q, len_d;
   logic [7:0]    csum_q, csum_d;
   logic [7:0]    rx_csum_q, rx_csum_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          mem_we_d;
   addr_t         mem_addr_d;
   logic [7:0]    mem_wdata_d;
   logic          hold_d, done_d, err_d;
   logic          accept;
   logic          in_frame;

   assign in_ready  = (state_q != ST_CHECK);
   assign accept    = in_valid && in_ready;
   assign in_frame  = (state_q != ST_IDLE) && (state_q != ST_CHECK);
   assign dbg_state = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         csum_q    <= '0;
         rx_csum_q <= '0;
         tmo_q     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_hold  <= 1'b1;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         csum_q    <= csum_d;
         rx_csum_q <= rx_csum_d;
         tmo_q     <= tmo_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         cpu_hold  <= hold_d;
         load_done <= done_d;
         load_err  <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      csum_d      = csum_q;
      rx_csum_d   = rx_csum_q;
      tmo_d       = '0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      hold_d      = cpu_hold;
      done_d      = 1'b0;
      err_d       = load_err;

      if (in_frame && !accept)
         tmo_d = tmo_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            // Non-SYNC bytes are consumed and dropped.
            if (accept && in_data == SYNC_BYTE) begin
               state_d = ST_ADDR_LO;
               csum_d  = '0;
               err_d   = 1'b0;
               hold_d  = 1'b1;
            end
         end
         ST_ADDR_LO: begin
            if (accept) begin
               addr_d[7:0] = in_data;
               csum_d      = csum_add(csum_q, in_data);
               state_d     = ST_ADDR_HI;
            end
         end
         ST_ADDR_HI: begin
            if (accept) begin
               addr_d[15:8] = in_data;
               csum_d       = csum_add(csum_q, in_data);
               state_d      = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (accept) begin
               len_d[7:0] = in_data;
               csum_d     = csum_add(csum_q, in_data);
               state_d    = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (accept) begin
               len_d[15:8] = in_data;
               csum_d      = csum_add(csum_q, in_data);
               state_d     = ({in_data, len_q[7:0]} == 16'd0) ? ST_CSUM : ST_DATA;
            end
         end
         ST_DATA: begin
            // SYNC_BYTE here is payload; the write lands one cycle after the accept.
            if (accept) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = in_data;
               addr_d      = addr_q + 16'd1;
               len_d       = len_q - 16'd1;
               csum_d      = csum_add(csum_q, in_data);
               if (len_q == 16'd1)
                  state_d = ST_CSUM;
            end
         end
         ST_CSUM: begin
            if (accept) begin
               rx_csum_d = in_data;
               state_d   = ST_CHECK;
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
            if (rx_csum_q == csum_q) begin
               done_d = 1'b1;
               hold_d = 1'b0;
            end else begin
               err_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Stalled sender: abandon the frame, keep the processor held.
      if (in_frame && !accept && tmo_q == TMO_LAST) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
         hold_d  = 1'b1;
         tmo_d   = '0;
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: frames with hand-computed checksums, write
// scoreboard on the memory port, timeout abort and mid-frame reset.
module tb_boot_loader;
   import cpu_pkg::*;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mem_we;
   addr_t       mem_addr;
   logic [7:0]  mem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;
   boot_state_e dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   logic [23:0] exp_q[$];

   boot_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
      .load_err(load_err), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard: every mem_we cycle must match the head of the expected queue
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_we", 32'(mem_we), 32'd0);
         end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            check("mem_write", {8'h00, mem_addr, mem_wdata}, {8'h00, e});
         end
      end
      if (load_done === 1'b1) done_cnt++;
   end

   // driver: called at posedge+1; returns at posedge+1 after the accept edge
   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && guard < 10) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 10) check("ready_wait", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] bytes[], input int n);
      for (int i = 0; i < n; i++) send_byte(bytes[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic end_of_frame(input string tag, input int exp_done, input logic exp_hold,
                               input logic exp_err);
      idle(4);
      check({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
      check({tag, "_hold"}, 32'(cpu_hold), 32'(exp_hold));
      check({tag, "_err"},  32'(load_err), 32'(exp_err));
      check({tag, "_pend"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
   endtask

   logic [7:0] fr[];

   initial begin
      // reset values
      #3 rst = 1'b1;
      #1;
      check("rst_hold",  32'(cpu_hold),  32'd1);
      check("rst_done",  32'(load_done), 32'd0);
      check("rst_err",   32'(load_err),  32'd0);
      check("rst_we",    32'(mem_we),    32'd0);
      check("rst_addr",  32'(mem_addr),  32'd0);
      check("rst_wdata", 32'(mem_wdata), 32'd0);
      check("rst_ready", 32'(in_ready),  32'd1);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(2);

      // good 3-byte frame, checksum 00+10+03+00+11+22+33 = 79
      exp_q.push_back({16'h1000, 8'h11});
      exp_q.push_back({16'h1001, 8'h22});
      exp_q.push_back({16'h1002, 8'h33});
      fr = '{8'hA5, 8'h00, 8'h10, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h79};
      send_frame(fr, 9);
      end_of_frame("good", 1, 1'b0, 1'b0);

      // same frame, bad checksum: writes stand, error, no done
      exp_q.push_back({16'h1000, 8'h11});
      exp_q.push_back({16'h1001, 8'h22});
      exp_q.push_back({16'h1002, 8'h33});
      fr = '{8'hA5, 8'h00, 8'h10, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h78};
      send_frame(fr, 9);
      end_of_frame("badsum", 1, 1'b1, 1'b1);

      // address wrap; FF+FF+02+00+AA+BB = 0x365 -> 65
      exp_q.push_back({16'hFFFF, 8'hAA});
      exp_q.push_back({16'h0000, 8'hBB});
      fr = '{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'h65};
      send_frame(fr, 8);
      end_of_frame("wrap", 2, 1'b0, 1'b0);

      // zero length: straight to checksum, no writes
      fr = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h00, 8'h20};
      send_frame(fr, 6);
      end_of_frame("zlen", 3, 1'b0, 1'b0);

      // SYNC value inside the payload is data; 00+40+02+00+A5+01 = E8
      exp_q.push_back({16'h4000, 8'hA5});
      exp_q.push_back({16'h4001, 8'h01});
      fr = '{8'hA5, 8'h00, 8'h40, 8'h02, 8'h00, 8'hA5, 8'h01, 8'hE8};
      send_frame(fr, 8);
      end_of_frame("insync", 4, 1'b0, 1'b0);

      // junk ignored, then a stalled frame times out
      send_byte(8'h00);
      send_byte(8'h3C);
      check("junk_state", 32'(dbg_state), 32'(ST_IDLE));
      check("junk_hold",  32'(cpu_hold),  32'd0);
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h10);
      check("tmo_hold_set", 32'(cpu_hold), 32'd1);
      idle(TMO - 1);
      check("tmo_not_yet", 32'(dbg_state), 32'(ST_LEN_LO));
      check("tmo_err_pre", 32'(load_err),  32'd0);
      idle(1);
      check("tmo_state", 32'(dbg_state), 32'(ST_IDLE));
      check("tmo_err",   32'(load_err),  32'd1);
      check("tmo_hold",  32'(cpu_hold),  32'd1);

      // recovery frame; 00+30+01+00+5A = 8B
      exp_q.push_back({16'h3000, 8'h5A});
      fr = '{8'hA5, 8'h00, 8'h30, 8'h01, 8'h00, 8'h5A, 8'h8B};
      send_frame(fr, 7);
      end_of_frame("recover", 5, 1'b0, 1'b0);

      // reset during DATA after the first of three bytes
      exp_q.push_back({16'h1000, 8'h11});
      fr = '{8'hA5, 8'h00, 8'h10, 8'h03, 8'h00, 8'h11};
      send_frame(fr, 6);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
      check("mrst_hold",  32'(cpu_hold),  32'd1);
      check("mrst_we",    32'(mem_we),    32'd0);
      check("mrst_addr",  32'(mem_addr),  32'd0);
      check("mrst_ready", 32'(in_ready),  32'd1);
      check("mrst_pend",  32'(exp_q.size()), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      send_byte(8'h22);
      send_byte(8'h33);
      idle(4);
      check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check("post_rst_done",  32'(done_cnt),  32'd5);
      check("post_rst_hold",  32'(cpu_hold),  32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
